// File: rtl/drops_pkg.sv
// Shared encodings and widths for the drops game controller.
// Optional build macro DROPS_LIVES_EN is consumed by the interface and top.
package drops_pkg;
  localparam int PY_W = 7;
  localparam int SC_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_e;
endpackage

// File: rtl/drops_game_ctrl_if.sv
// Frame-level signal bundle between pins/renderer and the game controller.
// DROPS_LIVES_EN adds the lives output.
interface drops_game_ctrl_if;
  import drops_pkg::*;
  logic            frame_tick;
  logic            btn_up;
  logic            btn_down;
  logic            collision;
  logic            pass;
  logic [PY_W-1:0] player_y;
  logic            scroll_pulse;
  logic [SC_W-1:0] score;
  logic [1:0]      state;
  logic            blink;
`ifdef DROPS_LIVES_EN
  logic [1:0]      lives;
  modport master (output frame_tick, btn_up, btn_down, collision, pass,
                  input  player_y, scroll_pulse, score, state, blink, lives);
  modport slave  (input  frame_tick, btn_up, btn_down, collision, pass,
                  output player_y, scroll_pulse, score, state, blink, lives);
`else
  modport master (output frame_tick, btn_up, btn_down, collision, pass,
                  input  player_y, scroll_pulse, score, state, blink);
  modport slave  (input  frame_tick, btn_up, btn_down, collision, pass,
                  output player_y, scroll_pulse, score, state, blink);
`endif
endinterface

// File: rtl/drops_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, frame-sampled stability counter,
// debounced level (registered) and its rising edge (valid on the frame_tick cycle).
module drops_btn_debounce #(
  parameter int DEB_FRAMES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic btn,
  output logic lvl,
  output logic rise
);
  localparam logic [7:0] DEB_N = 8'(DEB_FRAMES);

  logic [1:0] sync_q, sync_d;
  logic       deb_q, deb_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], btn};
    deb_d  = deb_q;
    cnt_d  = cnt_q;
    if (frame_tick) begin
      // counter tracks consecutive samples that disagree with the accepted level
      if (sync_q[1] == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q + 8'd1 >= DEB_N) begin
        deb_d = sync_q[1];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lvl  = deb_q;
  assign rise = deb_d & ~deb_q;
endmodule

// File: rtl/drops_game_ctrl.sv
// Per-frame game sequencer: player motion, scroll pacing, score and game state.
// DROPS_LIVES_EN adds a 3-life counter; HIT then returns to PLAY until lives run out.
module drops_game_ctrl
  import drops_pkg::*;
#(
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 100,
  parameter int Y_START    = 50,
  parameter int STEP       = 2,
  parameter int DEB_FRAMES = 2,
  parameter int SCROLL_DIV = 2,
  parameter int HIT_FRAMES = 60
) (
  input logic clk,
  input logic rst,
  drops_game_ctrl_if.slave io
);
  localparam logic [7:0]      Y_MIN8  = 8'(Y_MIN);
  localparam logic [7:0]      Y_MAX8  = 8'(Y_MAX);
  localparam logic [7:0]      STEP8   = 8'(STEP);
  localparam logic [PY_W-1:0] Y_ST    = PY_W'(Y_START);
  localparam logic [7:0]      SDIV_M1 = 8'(SCROLL_DIV - 1);
  localparam logic [7:0]      HIT_N   = 8'(HIT_FRAMES);

  state_e          state_q, state_d;
  logic [PY_W-1:0] py_q, py_d;
  logic [SC_W-1:0] score_q, score_d;
  logic [7:0]      sdiv_q, sdiv_d, hit_q, hit_d;
  logic            scroll_q, scroll_d, blink_q, blink_d;
  logic            col_q, col_d, pass_q, pass_d;
  logic            up_lvl, up_rise, dn_lvl, dn_rise, press, col_now, pass_now;
  logic [7:0]      py8, py_up, py_dn;
`ifdef DROPS_LIVES_EN
  logic [1:0]      lives_q, lives_d;
`endif

  drops_btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_up (
    .clk(clk), .rst(rst), .frame_tick(io.frame_tick), .btn(io.btn_up),
    .lvl(up_lvl), .rise(up_rise));
  drops_btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_dn (
    .clk(clk), .rst(rst), .frame_tick(io.frame_tick), .btn(io.btn_down),
    .lvl(dn_lvl), .rise(dn_rise));

  // rising edge of (up | down): something rose while both were previously low
  assign press = (up_rise | dn_rise) & ~(up_lvl | dn_lvl);

  always_comb begin
    state_d  = state_q;
    py_d     = py_q;
    score_d  = score_q;
    sdiv_d   = sdiv_q;
    hit_d    = hit_q;
    blink_d  = blink_q;
    scroll_d = 1'b0;
`ifdef DROPS_LIVES_EN
    lives_d  = lives_q;
`endif
    col_now  = col_q | io.collision;
    pass_now = pass_q | io.pass;
    col_d    = col_now;
    pass_d   = pass_now;
    py8      = {1'b0, py_q};
    py_up    = (py8 < Y_MIN8 + STEP8) ? Y_MIN8 : py8 - STEP8;
    py_dn    = (py8 + STEP8 > Y_MAX8) ? Y_MAX8 : py8 + STEP8;
    if (io.frame_tick) begin
      col_d  = 1'b0;
      pass_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          py_d    = Y_ST;
          score_d = '0;
          sdiv_d  = '0;
          hit_d   = '0;
          blink_d = 1'b1;
`ifdef DROPS_LIVES_EN
          lives_d = 2'd3;
`endif
          if (press) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (up_lvl && !dn_lvl)      py_d = py_up[PY_W-1:0];
          else if (dn_lvl && !up_lvl) py_d = py_dn[PY_W-1:0];
          if (sdiv_q >= SDIV_M1) begin
            sdiv_d   = '0;
            scroll_d = 1'b1;
          end else begin
            sdiv_d = sdiv_q + 8'd1;
          end
          if (col_now) begin
            state_d = ST_HIT;
            hit_d   = '0;
            blink_d = 1'b1;
          end else if (pass_now && score_q != '1) begin
            score_d = score_q + 1'b1;
          end
        end
        ST_HIT: begin
          hit_d = hit_q + 8'd1;
          if (hit_d[1:0] == 2'b00) blink_d = ~blink_q;
          if (hit_d >= HIT_N) begin
            hit_d   = '0;
            blink_d = 1'b1;
`ifdef DROPS_LIVES_EN
            lives_d = lives_q - 2'd1;
            if (lives_d != 2'd0) begin
              state_d = ST_PLAY;
              py_d    = Y_ST;
              sdiv_d  = '0;
            end else begin
              state_d = ST_OVER;
            end
`else
            state_d = ST_OVER;
`endif
          end
        end
        ST_OVER: begin
          if (press) begin
            state_d = ST_IDLE;
            py_d    = Y_ST;
            score_d = '0;
`ifdef DROPS_LIVES_EN
            lives_d = 2'd3;
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      py_q     <= Y_ST;
      score_q  <= '0;
      sdiv_q   <= '0;
      hit_q    <= '0;
      scroll_q <= 1'b0;
      blink_q  <= 1'b1;
      col_q    <= 1'b0;
      pass_q   <= 1'b0;
`ifdef DROPS_LIVES_EN
      lives_q  <= 2'd3;
`endif
    end else begin
      state_q  <= state_d;
      py_q     <= py_d;
      score_q  <= score_d;
      sdiv_q   <= sdiv_d;
      hit_q    <= hit_d;
      scroll_q <= scroll_d;
      blink_q  <= blink_d;
      col_q    <= col_d;
      pass_q   <= pass_d;
`ifdef DROPS_LIVES_EN
      lives_q  <= lives_d;
`endif
    end
  end

  assign io.player_y     = py_q;
  assign io.score        = score_q;
  assign io.state        = state_q;
  assign io.scroll_pulse = scroll_q;
  assign io.blink        = blink_q;
`ifdef DROPS_LIVES_EN
  assign io.lives        = lives_q;
`endif
endmodule

// File: tb/tb_drops_game_ctrl.sv
// Scoreboard bench for drops_game_ctrl: expectations are queued tagged with the
// frame (or cycle) after which they hold; a monitor pops them as frames complete.
module tb_drops_game_ctrl;
  import drops_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  drops_game_ctrl_if io();
  drops_game_ctrl dut (.clk(clk), .rst(rst), .io(io));

  typedef enum int {K_Y, K_SCORE, K_STATE, K_BLINK, K_SCROLL, K_LIVES} kind_e;
  typedef struct {
    int    fr;
    int    cy;
    kind_e k;
    int    v;
    string nm;
  } exp_t;

  exp_t q[$];
  int fcnt = 0, ccnt = 0, scnt = 0, total = 0, bad = 0;

  always @(posedge clk) begin
    ccnt <= ccnt + 1;
    if (io.frame_tick) fcnt <= fcnt + 1;
  end

  function automatic integer actual(input kind_e k);
    case (k)
      K_Y:      return integer'(io.player_y);
      K_SCORE:  return integer'(io.score);
      K_STATE:  return integer'(io.state);
      K_BLINK:  return integer'(io.blink);
      K_SCROLL: return scnt;
`ifdef DROPS_LIVES_EN
      K_LIVES:  return integer'(io.lives);
`endif
      default:  return -1;
    endcase
  endfunction

  // monitor: count scroll strobes each cycle, then retire due expectations
  initial begin
    exp_t   e;
    integer a;
    forever begin
      @(negedge clk);
      if (io.scroll_pulse === 1'b1) scnt++;
      while (q.size() > 0 && fcnt >= q[0].fr && ccnt >= q[0].cy) begin
        e = q.pop_front();
        a = actual(e.k);
        total++;
        if (a !== e.v) begin
          bad++;
          $display("FAIL %s: got %0d want %0d (frame %0d)", e.nm, a, e.v, fcnt);
        end
      end
    end
  end

  task automatic chk(input int fr, input kind_e k, input int v, input string nm);
    exp_t e;
    e.fr = fr; e.cy = 0; e.k = k; e.v = v; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic chk_cy(input int cy, input kind_e k, input int v, input string nm);
    exp_t e;
    e.fr = 0; e.cy = cy; e.k = k; e.v = v; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic frame(input bit p, input bit c);
    @(negedge clk); io.pass = p; io.collision = c;
    @(negedge clk); io.pass = 1'b0; io.collision = 1'b0;
    repeat (2) @(negedge clk);
    io.frame_tick = 1'b1;
    @(negedge clk); io.frame_tick = 1'b0;
  endtask

  task automatic nf(input int n);
    for (int i = 0; i < n; i++) frame(1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: pending=%0d want 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_reset(input bit first);
    int c;
    @(negedge clk); rst = 1'b1;
    c = ccnt + 1;
    chk_cy(c, K_Y, 50, "rst_y");
    chk_cy(c, K_SCORE, 0, "rst_score");
    chk_cy(c, K_STATE, 0, "rst_state");
    chk_cy(c, K_BLINK, 1, "rst_blink");
`ifdef DROPS_LIVES_EN
    chk_cy(c, K_LIVES, 3, "rst_lives");
`endif
    if (first) chk_cy(c, K_SCROLL, 0, "rst_scroll");
    @(negedge clk); rst = 1'b0;
  endtask

  // collision frame (with pass) followed by 60 HIT frames
  task automatic hit_phase(input int y, input bit last, input int lives_after);
    int s;
    s = fcnt;
    chk(s + 1, K_STATE, 2, "col_state");
    chk(s + 1, K_SCORE, 5, "col_beats_pass");
    chk(s + 1, K_Y, y, "col_y");
    chk(s + 1, K_BLINK, 1, "hit_blink_entry");
    chk(s + 4, K_BLINK, 1, "hit_blink3");
    chk(s + 5, K_BLINK, 0, "hit_blink4");
    chk(s + 9, K_BLINK, 1, "hit_blink8");
    chk(s + 53, K_BLINK, 0, "hit_blink52");
    chk(s + 60, K_STATE, 2, "hit59_state");
    chk(s + 61, K_SCROLL, 57, "hit_scroll_frozen");
    chk(s + 61, K_BLINK, 1, "hit_end_blink");
`ifdef DROPS_LIVES_EN
    chk(s + 61, K_LIVES, lives_after, "lives_dec");
    chk(s + 61, K_STATE, last ? 3 : 1, "hit_end_state");
    if (!last) chk(s + 61, K_Y, 50, "lives_y_reload");
`else
    chk(s + 61, K_STATE, 3, "hit_end_state");
    if (lives_after != 0) chk(s + 61, K_STATE, 1, "lives_unused");
`endif
    frame(1'b1, 1'b1);
    nf(49);
    if (last) io.btn_up = 1'b1;
    nf(11);
  endtask

  int b, o, g;

  initial begin
    io.frame_tick = 1'b0; io.btn_up = 1'b0; io.btn_down = 1'b0;
    io.collision = 1'b0;  io.pass = 1'b0;
    repeat (2) @(negedge clk);
    do_reset(1'b1);

    chk(fcnt + 10, K_STATE, 0, "idle_state");
    chk(fcnt + 10, K_SCROLL, 0, "idle_no_scroll");
    chk(fcnt + 10, K_Y, 50, "idle_y");
    nf(10);

    // start: up press accepted after two equal samples
    io.btn_up = 1'b1;
    chk(fcnt + 1, K_STATE, 0, "deb_wait");
    chk(fcnt + 2, K_STATE, 1, "start");
    nf(2);
    b = fcnt;
    chk(b + 1, K_Y, 48, "up_step");
    chk(b + 1, K_SCROLL, 0, "scroll_p1");
    chk(b + 2, K_SCROLL, 1, "scroll_p2");
    chk(b + 25, K_Y, 0, "up_reach_min");
    chk(b + 30, K_Y, 0, "up_sat_min");
    chk(b + 30, K_SCROLL, 15, "scroll_30");
    nf(30);

    io.btn_up = 1'b0; io.btn_down = 1'b1;
    chk(b + 32, K_Y, 0, "swap_deb");
    chk(b + 33, K_Y, 2, "down_step");
    chk(b + 81, K_Y, 98, "down_98");
    chk(b + 87, K_Y, 100, "down_sat_max");
    chk(b + 87, K_SCROLL, 43, "scroll_87");
    nf(57);
    io.btn_down = 1'b0;
    chk(b + 88, K_SCROLL, 44, "scroll_88");
    chk(b + 89, K_Y, 100, "release_hold");
    nf(2);

    chk(b + 90, K_SCORE, 1, "score1");
    chk(b + 94, K_SCORE, 5, "score5");
    repeat (5) frame(1'b1, 1'b0);

    io.btn_up = 1'b1; nf(4); io.btn_up = 1'b0;
    chk(b + 101, K_Y, 92, "move_up_92");
    nf(3);
    io.btn_down = 1'b1; nf(1); io.btn_down = 1'b0;
    chk(b + 105, K_Y, 92, "glitch_ignored");
    nf(3);
    io.btn_up = 1'b1; io.btn_down = 1'b1;
    chk(b + 111, K_Y, 92, "both_held");
    nf(6);
    io.btn_up = 1'b0; io.btn_down = 1'b0;
    chk(b + 114, K_Y, 92, "both_release");
    chk(b + 114, K_SCROLL, 57, "scroll_114");
    nf(3);

`ifdef DROPS_LIVES_EN
    hit_phase(92, 1'b0, 2);
    hit_phase(50, 1'b0, 1);
    hit_phase(50, 1'b1, 0);
`else
    hit_phase(92, 1'b1, 0);
`endif

    // OVER: held button ignored, fresh press returns to IDLE
    o = fcnt;
    chk(o + 5, K_STATE, 3, "held_no_press");
    chk(o + 5, K_SCORE, 5, "over_score_held");
    nf(5);
    io.btn_up = 1'b0;
    chk(o + 8, K_STATE, 3, "over_release");
    nf(3);
    io.btn_down = 1'b1;
    chk(o + 9, K_STATE, 3, "over_deb_wait");
    chk(o + 10, K_STATE, 0, "restart_idle");
    chk(o + 10, K_SCORE, 0, "restart_score");
    chk(o + 10, K_Y, 50, "restart_y");
`ifdef DROPS_LIVES_EN
    chk(o + 10, K_LIVES, 3, "restart_lives");
`endif
    nf(2);

    // second game: score saturation, then reset in HIT
    io.btn_down = 1'b0; nf(2);
    io.btn_down = 1'b1;
    chk(fcnt + 2, K_STATE, 1, "start2");
    nf(2);
    io.btn_down = 1'b0;
    g = fcnt;
    chk(g + 254, K_SCORE, 254, "score254");
    chk(g + 255, K_SCORE, 255, "score255");
    chk(g + 300, K_SCORE, 255, "score_sat");
    repeat (300) frame(1'b1, 1'b0);
    g = fcnt;
    chk(g + 1, K_STATE, 2, "hit2_state");
    chk(g + 1, K_SCORE, 255, "hit2_score");
    chk(g + 6, K_BLINK, 0, "hit2_blink");
    frame(1'b0, 1'b1);
    nf(5);
    drain();
    do_reset(1'b0);
    drain();
    chk(fcnt + 3, K_STATE, 0, "post_rst_idle");
    nf(3);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
